// File: rtl/gcd_ctrl_8_bit_if.sv
// Operand/result bundle between the GCD engine and its host.
// The host drives start and operands; the engine returns status, result and iteration count.
interface gcd_ctrl_8_bit_if;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] iter_cnt;

  modport master (
    output start, a_in, b_in,
    input  busy, done, result, iter_cnt
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, result, iter_cnt
  );
endinterface

// File: rtl/gcd_ctrl_8_bit.sv
// Subtraction-based 8-bit GCD engine: n subtractions take n+1 busy cycles, then done holds.
// start is only accepted in IDLE/DONE; requests made while busy are dropped.
module comp_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);
endmodule

module gcd_ctrl_8_bit (
  input  logic              clk,
  input  logic              rst,
  gcd_ctrl_8_bit_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] a_q, b_q, a_nx, b_nx;
  logic [7:0] res_q, res_nx;
  logic [7:0] cnt_q, cnt_nx;
  logic       a_gt_b, a_eq_b, a_lt_b;

  comp_8_bit u_comp (
    .a  (a_q),
    .b  (b_q),
    .gt (a_gt_b),
    .eq (a_eq_b),
    .lt (a_lt_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      res_q <= 8'd0;
      cnt_q <= 8'd0;
    end else begin
      state <= state_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      res_q <= res_nx;
      cnt_q <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    res_nx   = res_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          a_nx     = bus.a_in;
          b_nx     = bus.b_in;
          cnt_nx   = 8'd0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // Zero checks precede the comparator so gcd(0,0) resolves to B=0.
        if (~|a_q) begin
          res_nx   = b_q;
          state_nx = DONE;
        end else if (~|b_q) begin
          res_nx   = a_q;
          state_nx = DONE;
        end else if (a_eq_b) begin
          res_nx   = a_q;
          state_nx = DONE;
        end else if (a_gt_b) begin
          a_nx   = a_q - b_q;
          cnt_nx = cnt_q + 8'd1;
        end else if (a_lt_b) begin
          b_nx   = b_q - a_q;
          cnt_nx = cnt_q + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy     = (state == BUSY);
  assign bus.done     = (state == DONE);
  assign bus.result   = res_q;
  assign bus.iter_cnt = cnt_q;
endmodule

// File: tb/tb_gcd_ctrl_8_bit.sv
// Directed bench for gcd_ctrl_8_bit: latency, results, iteration counts, reset abort, ignored starts.
module tb_gcd_ctrl_8_bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  gcd_ctrl_8_bit_if bus ();

  gcd_ctrl_8_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a job and wait for done; optionally pokes start with (5,5) in the 2nd busy cycle.
  task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int exp_res, input int exp_n, input bit poke);
    int k;
    int busy_cyc;
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    step();
    bus.start = 1'b0;
    chk({tag, "_busy_after_accept"}, int'(bus.busy), 1);
    chk({tag, "_done_low_after_accept"}, int'(bus.done), 0);
    k = 0;
    busy_cyc = 0;
    while (!bus.done && k < 400) begin
      if (bus.busy) busy_cyc++;
      if (poke && k == 1) begin
        bus.start = 1'b1;
        bus.a_in  = 8'd5;
        bus.b_in  = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      step();
      k++;
    end
    bus.start = 1'b0;
    chk({tag, "_done_edge"}, k, exp_n + 1);
    chk({tag, "_busy_cycles"}, busy_cyc, exp_n + 1);
    chk({tag, "_busy_low_in_done"}, int'(bus.busy), 0);
    chk({tag, "_result"}, int'(bus.result), exp_res);
    chk({tag, "_iter_cnt"}, int'(bus.iter_cnt), exp_n);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a_in  = 8'd0;
    bus.b_in  = 8'd0;
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_iter", int'(bus.iter_cnt), 0);
    rst = 1'b0;
    step();
    chk("idle_busy", int'(bus.busy), 0);

    run_job("g12_8", 8'd12, 8'd8, 4, 2, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("hold_done", int'(bus.done), 1);
    chk("hold_result", int'(bus.result), 4);
    chk("hold_iter", int'(bus.iter_cnt), 2);

    run_job("g100_75", 8'd100, 8'd75, 25, 3, 1'b0);
    run_job("g255_1", 8'd255, 8'd1, 1, 254, 1'b0);
    run_job("g0_7", 8'd0, 8'd7, 7, 0, 1'b0);
    run_job("g9_0", 8'd9, 8'd0, 9, 0, 1'b0);
    run_job("g0_0", 8'd0, 8'd0, 0, 0, 1'b0);
    run_job("g13_13", 8'd13, 8'd13, 13, 0, 1'b0);
    run_job("g48_18_poke", 8'd48, 8'd18, 6, 4, 1'b1);

    bus.start = 1'b1;
    bus.a_in  = 8'd200;
    bus.b_in  = 8'd3;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("abort_busy_before", int'(bus.busy), 1);
    chk("abort_iter_before", int'(bus.iter_cnt), 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_iter", int'(bus.iter_cnt), 0);
    step();
    chk("abort_idle_busy", int'(bus.busy), 0);
    chk("abort_idle_done", int'(bus.done), 0);
    run_job("g21_14", 8'd21, 8'd14, 7, 2, 1'b0);

    // Held start relaunches from DONE every n+2 cycles with one done cycle between jobs.
    bus.start = 1'b1;
    bus.a_in  = 8'd12;
    bus.b_in  = 8'd8;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("b2b_done1", int'(bus.done), 1);
    step();
    chk("b2b_relaunch_busy", int'(bus.busy), 1);
    chk("b2b_relaunch_done", int'(bus.done), 0);
    for (int i = 0; i < 3; i++) step();
    chk("b2b_done2", int'(bus.done), 1);
    bus.start = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gcd_ctrl_8_bit.md
Name: gcd_ctrl_8_bit

Overview:
- Sequencing controller and register datapath for an 8-bit subtraction-based GCD engine.
- Accepts an operand pair on a start handshake and iterates "subtract smaller from larger" until the operands are equal or one is zero.
- All magnitude decisions come from one instance of the team's comp_8_bit (gt/eq/lt); no other comparator logic is permitted.
- Sits between the operand source (host/testbench) and result consumer; top-level GCD block of the design.

Parameters:
- none: width fixed at 8 bits to match comp_8_bit.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin; sampled only in IDLE or DONE.
- a_in  input  8  operand A; sampled on the accepting edge.
- b_in  input  8  operand B; sampled on the accepting edge.
- busy  output  1  high while in BUSY.
- done  output  1  high while in DONE; held until a new start is accepted or reset.
- result  output  8  GCD value; valid while done=1.
- iter_cnt  output  8  number of subtractions performed for the current/last job.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE; busy=0, done=0, result=0, iter_cnt=0; internal A/B regs=0. Reset mid-computation aborts the job with no result.
- States:
  - IDLE: start=1 -> A<=a_in, B<=b_in, iter_cnt<=0, go to BUSY. Otherwise stay.
  - BUSY: one decision per cycle, using comp_8_bit on the current A, B.
    - A==0 -> result<=B, go to DONE.
    - else B==0 -> result<=A, go to DONE.
    - else eq -> result<=A, go to DONE.
    - else gt -> A<=A-B, iter_cnt++.
    - else lt -> B<=B-A, iter_cnt++.
  - DONE: done=1; result and iter_cnt held. start=1 -> load as in IDLE, done falls on the same edge, go to BUSY. Otherwise stay.
- start is ignored in BUSY: no reload, no restart, no side effect.
- busy and done are registered state decodes, never both high.
- Arithmetic:
  - Subtraction is unsigned 8-bit and is only performed when the minuend is strictly greater, so it never underflows.
  - iter_cnt never exceeds 254 (worst case 255,1), so it never wraps.
- Latency:
  - Let the accepting edge be edge 0 and n the number of subtractions.
  - done rises after edge n+1; busy is high for exactly n+1 cycles.
- Zero operands:
  - gcd(0,x)=x and gcd(x,0)=x, with n=0.
  - gcd(0,0)=0: the A==0 check takes priority, so result=B=0.
- Operands equal at load: n=0, result=A.
- Back-to-back jobs: a start held high continuously relaunches from DONE every n+2 cycles. done is high for exactly one cycle between jobs.

Test Plan:
- Reset, then start with (12,8) -> busy high 3 cycles; done rises after edge 3; result=4, iter_cnt=2; done/result hold until next start.
- Start with (255,1) -> result=1, iter_cnt=254; done rises after edge 255.
- Start with (0,7) -> result=7, iter_cnt=0, done after edge 1. Then start with (9,0) -> result=9. Then start with (0,0) -> result=0.
- Start with (48,18); pulse start with (5,5) during BUSY -> second request ignored; result=6, iter_cnt=4.
- Start with (200,3); assert rst in the 10th BUSY cycle -> next edge: busy=0, done=0, result=0, iter_cnt=0, IDLE. Then start with (21,14) -> result=7.
- From DONE of (12,8), apply start with (100,75) -> done falls on the accepting edge; result=25, iter_cnt=3.
